rvfi_imem_track_check: RTL and testbench

RVFI_IMEM_TRACK_CHECK -- requirements
Module: rvfi_imem_track_check

---
 rtl/rvfi_check_pkg.sv | 12 +
 rtl/rvfi_imem_slot.sv | 89 ++++++++
 rtl/rvfi_imem_track_check.sv | 122 ++++++++++++
 tb/tb_rvfi_imem_track_check.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rvfi_check_pkg.sv
// Shared types and constants for the RVFI instruction-memory consistency checkers.
package rvfi_check_pkg;

   typedef enum logic {
      EMPTY   = 1'b0,
      LATCHED = 1'b1
   } slot_state_e;

   localparam logic [2:0] ERR_SLOT_ALIGN = 3'd7;
   localparam int         CHECK_COUNT_W  = 16;

endpackage

// File: rtl/rvfi_imem_slot.sv
// One tracked halfword: latches the first fetched copy, flags later fetches that disagree,
// and forgets the copy when a store touches either of its two bytes.
module rvfi_imem_slot
   import rvfi_check_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NRET = 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [XLEN-1:0]        track_addr_i,
   input  logic [NRET-1:0]        rvfi_valid_i,
   input  logic [NRET*32-1:0]     rvfi_insn_i,
   input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata_i,
   input  logic [NRET*XLEN-1:0]   rvfi_mem_addr_i,
   input  logic [NRET*XLEN/8-1:0] rvfi_mem_wmask_i,
   output logic                   slot_valid_o,
   output logic [15:0]            slot_data_o,
   output logic [NRET-1:0]        cmp_o,
   output logic [NRET-1:0]        mis_o
);

   localparam int NB = XLEN/8;
   localparam int LB = $clog2(NB);

   slot_state_e     state_q, state_d;
   logic [15:0]     data_q, data_d;
   logic [XLEN-1:0] a, pc, ma;
   logic [31:0]     insn;
   logic [NB-1:0]   wm;
   logic [15:0]     hw;
   logic            lo, hi, st_hit;

   assign a = track_addr_i & ~XLEN'(1);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Channels are walked in order so a latch or store on channel i is seen by channel i+1.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cmp_o   = '0;
      mis_o   = '0;
      pc      = '0;
      ma      = '0;
      insn    = '0;
      wm      = '0;
      hw      = '0;
      lo      = 1'b0;
      hi      = 1'b0;
      st_hit  = 1'b0;
      for (int c = 0; c < NRET; c++) begin
         pc   = rvfi_pc_rdata_i[c*XLEN +: XLEN];
         ma   = rvfi_mem_addr_i[c*XLEN +: XLEN];
         insn = rvfi_insn_i[c*32 +: 32];
         wm   = rvfi_mem_wmask_i[c*NB +: NB];
         lo   = rvfi_valid_i[c] && (pc == a);
         hi   = rvfi_valid_i[c] && (insn[1:0] == 2'b11) && ((pc + XLEN'(2)) == a);
         hw   = lo ? insn[15:0] : insn[31:16];
         if (lo || hi) begin
            if (state_d == EMPTY) begin
               state_d = LATCHED;
               data_d  = hw;
            end else begin
               cmp_o[c] = 1'b1;
               mis_o[c] = (hw != data_d);
            end
         end
         // A is even, so A and A+1 always share one aligned word.
         st_hit = rvfi_valid_i[c] && (ma[XLEN-1:LB] == a[XLEN-1:LB]) &&
                  (wm[{a[LB-1:1], 1'b0}] || wm[{a[LB-1:1], 1'b1}]);
         if (st_hit) state_d = EMPTY;
      end
   end

   always_comb begin
      slot_valid_o = (state_q == LATCHED);
      slot_data_o  = data_q;
   end

endmodule

// File: rtl/rvfi_imem_track_check.sv
// Instruction-memory consistency checker over RVFI: NADDR tracked halfwords, saturating
// compare counter and a first-error record.
module rvfi_imem_track_check
   import rvfi_check_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NRET       = 1,
   parameter int NADDR      = 2,
   parameter int COMPRESSED = 1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NADDR*XLEN-1:0]    track_addr,
   input  logic [NRET-1:0]          rvfi_valid,
   input  logic [NRET*64-1:0]       rvfi_order,
   input  logic [NRET*32-1:0]       rvfi_insn,
   input  logic [NRET*XLEN-1:0]     rvfi_pc_rdata,
   input  logic [NRET*XLEN-1:0]     rvfi_mem_addr,
   input  logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask,
   output logic [NADDR-1:0]         slot_valid,
   output logic [NADDR*16-1:0]      slot_data,
   output logic [CHECK_COUNT_W-1:0] check_count,
   output logic                     err,
   output logic [2:0]               err_slot,
   output logic [63:0]              err_order
);

   logic [NADDR-1:0][NRET-1:0] cmp, mis;

   logic [CHECK_COUNT_W-1:0] cnt_q, cnt_d;
   logic [CHECK_COUNT_W:0]   cnt_sum;
   logic                     err_q, err_d;
   logic [2:0]               err_slot_q, err_slot_d;
   logic [63:0]              err_order_q, err_order_d;
   logic                     new_err;
   logic [2:0]               new_slot;
   logic [63:0]              new_order;

   for (genvar s = 0; s < NADDR; s++) begin : g_slot
      rvfi_imem_slot #(
         .XLEN (XLEN),
         .NRET (NRET)
      ) u_slot (
         .clk              (clk),
         .resetn           (resetn),
         .track_addr_i     (track_addr[s*XLEN +: XLEN]),
         .rvfi_valid_i     (rvfi_valid),
         .rvfi_insn_i      (rvfi_insn),
         .rvfi_pc_rdata_i  (rvfi_pc_rdata),
         .rvfi_mem_addr_i  (rvfi_mem_addr),
         .rvfi_mem_wmask_i (rvfi_mem_wmask),
         .slot_valid_o     (slot_valid[s]),
         .slot_data_o      (slot_data[s*16 +: 16]),
         .cmp_o            (cmp[s]),
         .mis_o            (mis[s])
      );
   end

   always_comb begin
      cnt_sum = {1'b0, cnt_q};
      for (int s = 0; s < NADDR; s++)
         for (int c = 0; c < NRET; c++)
            cnt_sum = cnt_sum + {{CHECK_COUNT_W{1'b0}}, cmp[s][c]};
      cnt_d = cnt_sum[CHECK_COUNT_W] ? '1 : cnt_sum[CHECK_COUNT_W-1:0];
   end

   // Priority: lowest channel, then lowest slot, then the alignment check of that channel.
   always_comb begin
      new_err   = 1'b0;
      new_slot  = '0;
      new_order = '0;
      for (int c = 0; c < NRET; c++) begin
         for (int s = 0; s < NADDR; s++) begin
            if (!new_err && mis[s][c]) begin
               new_err   = 1'b1;
               new_slot  = 3'(s);
               new_order = rvfi_order[c*64 +: 64];
            end
         end
         if (COMPRESSED == 0 && !new_err && rvfi_valid[c] && rvfi_pc_rdata[c*XLEN+1]) begin
            new_err   = 1'b1;
            new_slot  = ERR_SLOT_ALIGN;
            new_order = rvfi_order[c*64 +: 64];
         end
      end
   end

   always_comb begin
      err_d       = err_q;
      err_slot_d  = err_slot_q;
      err_order_d = err_order_q;
      if (new_err && !err_q) begin
         err_d       = 1'b1;
         err_slot_d  = new_slot;
         err_order_d = new_order;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q       <= '0;
         err_q       <= 1'b0;
         err_slot_q  <= '0;
         err_order_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         err_slot_q  <= err_slot_d;
         err_order_q <= err_order_d;
      end
   end

`ifdef FORMAL
   always_comb if (resetn) assert (!new_err);
`endif

   assign check_count = cnt_q;
   assign err         = err_q;
   assign err_slot    = err_slot_q;
   assign err_order   = err_order_q;

endmodule

// File: tb/tb_rvfi_imem_track_check.sv
// Directed vector bench: a two-channel, two-slot checker plus a COMPRESSED=0 single-slot one.
module tb_rvfi_imem_track_check;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   // main DUT: XLEN=32, NRET=2, NADDR=2, COMPRESSED=1
   logic         resetn;
   logic [63:0]  track_addr;
   logic [1:0]   rvfi_valid;
   logic [127:0] rvfi_order;
   logic [63:0]  rvfi_insn, rvfi_pc_rdata, rvfi_mem_addr;
   logic [7:0]   rvfi_mem_wmask;
   logic [1:0]   slot_valid;
   logic [31:0]  slot_data;
   logic [15:0]  check_count;
   logic         err;
   logic [2:0]   err_slot;
   logic [63:0]  err_order;

   // alignment DUT: XLEN=32, NRET=1, NADDR=1, COMPRESSED=0
   logic         b_resetn;
   logic [31:0]  b_track_addr;
   logic         b_valid;
   logic [63:0]  b_order;
   logic [31:0]  b_insn, b_pc, b_mem_addr;
   logic [3:0]   b_wmask;
   logic         b_slot_valid;
   logic [15:0]  b_slot_data;
   logic [15:0]  b_count;
   logic         b_err;
   logic [2:0]   b_err_slot;
   logic [63:0]  b_err_order;

   rvfi_imem_track_check #(.XLEN(32), .NRET(2), .NADDR(2), .COMPRESSED(1)) dut (
      .clk(clk), .resetn(resetn), .track_addr(track_addr), .rvfi_valid(rvfi_valid),
      .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata),
      .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_wmask(rvfi_mem_wmask),
      .slot_valid(slot_valid), .slot_data(slot_data), .check_count(check_count),
      .err(err), .err_slot(err_slot), .err_order(err_order));

   rvfi_imem_track_check #(.XLEN(32), .NRET(1), .NADDR(1), .COMPRESSED(0)) dut_b (
      .clk(clk), .resetn(b_resetn), .track_addr(b_track_addr), .rvfi_valid(b_valid),
      .rvfi_order(b_order), .rvfi_insn(b_insn), .rvfi_pc_rdata(b_pc),
      .rvfi_mem_addr(b_mem_addr), .rvfi_mem_wmask(b_wmask),
      .slot_valid(b_slot_valid), .slot_data(b_slot_data), .check_count(b_count),
      .err(b_err), .err_slot(b_err_slot), .err_order(b_err_order));

   typedef struct {
      logic        r;
      logic [31:0] a0, a1;
      logic [1:0]  v;
      logic [31:0] pc0, i0, pc1, i1, ma0;
      logic [3:0]  wm0;
      logic [1:0]  sv;
      logic [15:0] sd0, sd1, cnt;
      logic        e;
      logic [2:0]  es;
      logic [63:0] eo;
   } vec_t;

   vec_t tv[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t V(logic r, logic [31:0] a0, logic [31:0] a1, logic [1:0] v,
                              logic [31:0] pc0, logic [31:0] i0, logic [31:0] pc1,
                              logic [31:0] i1, logic [31:0] ma0, logic [3:0] wm0,
                              logic [1:0] sv, logic [15:0] sd0, logic [15:0] sd1,
                              logic [15:0] cnt, logic e, logic [2:0] es, logic [63:0] eo);
      vec_t t;
      t.r = r; t.a0 = a0; t.a1 = a1; t.v = v; t.pc0 = pc0; t.i0 = i0; t.pc1 = pc1;
      t.i1 = i1; t.ma0 = ma0; t.wm0 = wm0; t.sv = sv; t.sd0 = sd0; t.sd1 = sd1;
      t.cnt = cnt; t.e = e; t.es = es; t.eo = eo;
      return t;
   endfunction

   task automatic check_main(input string name, input logic [1:0] sv, input logic [15:0] sd0,
                             input logic [15:0] sd1, input logic [15:0] cnt, input logic e,
                             input logic [2:0] es, input logic [63:0] eo);
      n_cmp++;
      if ({slot_valid, slot_data, check_count, err, err_slot, err_order} !==
          {sv, sd1, sd0, cnt, e, es, eo}) begin
         n_bad++;
         $display("FAIL %s: got sv=%b sd1=%h sd0=%h cnt=%0d err=%b slot=%0d ord=%0d ; want sv=%b sd1=%h sd0=%h cnt=%0d err=%b slot=%0d ord=%0d",
                  name, slot_valid, slot_data[31:16], slot_data[15:0], check_count, err,
                  err_slot, err_order, sv, sd1, sd0, cnt, e, es, eo);
      end
   endtask

   task automatic check_b(input string name, input logic sv, input logic [15:0] sd,
                          input logic [15:0] cnt, input logic e, input logic [2:0] es,
                          input logic [63:0] eo);
      n_cmp++;
      if ({b_slot_valid, b_slot_data, b_count, b_err, b_err_slot, b_err_order} !==
          {sv, sd, cnt, e, es, eo}) begin
         n_bad++;
         $display("FAIL %s: got sv=%b sd=%h cnt=%0d err=%b slot=%0d ord=%0d ; want sv=%b sd=%h cnt=%0d err=%b slot=%0d ord=%0d",
                  name, b_slot_valid, b_slot_data, b_count, b_err, b_err_slot, b_err_order,
                  sv, sd, cnt, e, es, eo);
      end
   endtask

   initial begin
      resetn = 1'b0; track_addr = '0; rvfi_valid = '0; rvfi_order = '0; rvfi_insn = '0;
      rvfi_pc_rdata = '0; rvfi_mem_addr = '0; rvfi_mem_wmask = '0;
      b_resetn = 1'b0; b_track_addr = 32'h100; b_valid = 1'b0; b_order = '0; b_insn = '0;
      b_pc = '0; b_mem_addr = '0; b_wmask = '0;

      //        r  a0            a1            v      pc0           i0            pc1           i1            ma0    wm0      sv     sd0      sd1      cnt e  es ord
      tv.push_back(V(0, 32'h100, 32'h102, 2'b01, 32'h100, 32'h00A00093, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b00, 16'h0, 16'h0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h100, 32'h102, 2'b01, 32'h100, 32'h00A00093, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b11, 16'h0093, 16'h00A0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h100, 32'h102, 2'b01, 32'h100, 32'h00A00093, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b11, 16'h0093, 16'h00A0, 16'd2, 0, 0, 0));
      tv.push_back(V(1, 32'h100, 32'h102, 2'b01, 32'h100, 32'h00B00093, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b11, 16'h0093, 16'h00A0, 16'd4, 1, 1, 6));
      tv.push_back(V(1, 32'h100, 32'h102, 2'b01, 32'h100, 32'h00C00013, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b11, 16'h0093, 16'h00A0, 16'd6, 1, 1, 6));
      tv.push_back(V(0, 32'h100, 32'h102, 2'b01, 32'h100, 32'h00A00093, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b00, 16'h0, 16'h0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h200, 32'h400, 2'b11, 32'h200, 32'h00004501, 32'h200, 32'h00004505, 32'h0, 4'b0000, 2'b01, 16'h4501, 16'h0, 16'd1, 1, 0, 13));
      tv.push_back(V(0, 32'h200, 32'h400, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b00, 16'h0, 16'h0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h500, 32'h500, 2'b01, 32'h500, 32'h00001111, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b11, 16'h1111, 16'h1111, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h500, 32'h500, 2'b11, 32'h500, 32'h00002221, 32'h500, 32'h00003331, 32'h0, 4'b0000, 2'b11, 16'h1111, 16'h1111, 16'd4, 1, 0, 18));
      tv.push_back(V(0, 32'h500, 32'h500, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b00, 16'h0, 16'h0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h300, 32'h600, 2'b01, 32'h300, 32'h00001234, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b01, 16'h1234, 16'h0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h300, 32'h600, 2'b01, 32'h800, 32'h00000013, 32'h0, 32'h0, 32'h300, 4'b0010, 2'b00, 16'h1234, 16'h0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h300, 32'h600, 2'b01, 32'h300, 32'h0000ABCD, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b01, 16'hABCD, 16'h0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h300, 32'h600, 2'b11, 32'h800, 32'h00000013, 32'h300, 32'h00005555, 32'h302, 4'b0001, 2'b01, 16'h5555, 16'h0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h300, 32'h600, 2'b01, 32'h300, 32'h00005555, 32'h0, 32'h0, 32'h300, 4'b0001, 2'b00, 16'h5555, 16'h0, 16'd1, 0, 0, 0));
      tv.push_back(V(0, 32'h300, 32'h600, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b00, 16'h0, 16'h0, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h0, 32'hFFFFFFFE, 2'b01, 32'hFFFFFFFE, 32'h12345673, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b11, 16'h1234, 16'h5673, 16'd0, 0, 0, 0));
      tv.push_back(V(1, 32'h0, 32'hFFFFFFFE, 2'b10, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h12345673, 32'h0, 4'b0000, 2'b11, 16'h1234, 16'h5673, 16'd2, 0, 0, 0));
      tv.push_back(V(1, 32'h0, 32'hFFFFFFFE, 2'b01, 32'h800, 32'h00000013, 32'h0, 32'h0, 32'hFFFFFFFC, 4'b1000, 2'b01, 16'h1234, 16'h5673, 16'd2, 0, 0, 0));
      tv.push_back(V(0, 32'h0, 32'hFFFFFFFE, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'b0000, 2'b00, 16'h0, 16'h0, 16'd0, 0, 0, 0));

      for (int i = 0; i < tv.size(); i++) begin
         resetn         = tv[i].r;
         track_addr     = {tv[i].a1, tv[i].a0};
         rvfi_valid     = tv[i].v;
         rvfi_order     = {64'(2*i+1), 64'(2*i)};
         rvfi_insn      = {tv[i].i1, tv[i].i0};
         rvfi_pc_rdata  = {tv[i].pc1, tv[i].pc0};
         rvfi_mem_addr  = {32'h0, tv[i].ma0};
         rvfi_mem_wmask = {4'b0000, tv[i].wm0};
         @(posedge clk); #1;
         check_main($sformatf("vec%0d", i), tv[i].sv, tv[i].sd0, tv[i].sd1, tv[i].cnt,
                    tv[i].e, tv[i].es, tv[i].eo);
      end

      // counter saturation: two slots on one address, two channels -> 4 compares per cycle
      resetn = 1'b1; track_addr = {32'h700, 32'h700}; rvfi_mem_wmask = '0;
      rvfi_valid = 2'b01; rvfi_pc_rdata = {32'h0, 32'h700}; rvfi_insn = {32'h0, 32'h1};
      @(posedge clk); #1;
      check_main("sat_latch", 2'b11, 16'h0001, 16'h0001, 16'd0, 0, 0, 0);
      rvfi_valid = 2'b11; rvfi_pc_rdata = {32'h700, 32'h700}; rvfi_insn = {32'h1, 32'h1};
      repeat (16383) @(posedge clk);
      #1;
      check_main("sat_below", 2'b11, 16'h0001, 16'h0001, 16'd65532, 0, 0, 0);
      @(posedge clk); #1;
      check_main("sat_clip", 2'b11, 16'h0001, 16'h0001, 16'hFFFF, 0, 0, 0);
      @(posedge clk); #1;
      check_main("sat_hold", 2'b11, 16'h0001, 16'h0001, 16'hFFFF, 0, 0, 0);
      resetn = 1'b0; rvfi_valid = '0;
      @(posedge clk); #1;
      check_main("sat_reset", 2'b00, 16'h0, 16'h0, 16'd0, 0, 0, 0);

      // COMPRESSED=0: misaligned retirement is flagged with the alignment slot code
      @(posedge clk); #1;
      check_b("b_reset", 1'b0, 16'h0, 16'd0, 0, 0, 0);
      b_resetn = 1'b1; b_valid = 1'b1; b_pc = 32'h102; b_insn = 32'h00000013; b_order = 64'd5;
      @(posedge clk); #1;
      check_b("b_align", 1'b0, 16'h0, 16'd0, 1, 3'd7, 64'd5);
      b_pc = 32'h100; b_order = 64'd6;
      @(posedge clk); #1;
      check_b("b_latch", 1'b1, 16'h0013, 16'd0, 1, 3'd7, 64'd5);
      b_resetn = 1'b0;
      @(posedge clk); #1;
      check_b("b_clear", 1'b0, 16'h0, 16'd0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
